attn_row_sched: RTL and testbench

- Row scheduler for the credit-pipelined attention engine.
- Holds one 4-feature query vector (Q0.7) and streams N key vectors against it. For each key it drives interleaved q/k byte pairs into the MAC+exp engine's slave handshake, then collects the 9-bit exp score.
- Forwards each score downstream and accumulates the softmax denominator. Emits the row sum after the last key.
- Sits between the host-side key/query streams and the engine instance.

---
 rtl/attn_row_sched.sv | 161 ++++++++++++++++
 tb/tb_attn_row_sched.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/attn_row_sched.sv
// rtl/attn_row_sched.sv - attention row scheduler: query load, q/k interleave to engine, score forward and saturating row sum
module attn_row_sched #(
  parameter int NKEYS = 8,
  parameter int SUM_W = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             q_vld,
  output logic             q_rdy,
  input  logic [7:0]       q_data,
  input  logic             k_vld,
  output logic             k_rdy,
  input  logic [7:0]       k_data,
  output logic             eng_vld,
  input  logic             eng_rdy,
  output logic [7:0]       eng_data,
  input  logic             res_vld,
  output logic             res_rdy,
  input  logic [8:0]       res_data,
  output logic             sc_vld,
  input  logic             sc_rdy,
  output logic [8:0]       sc_data,
  output logic [7:0]       sc_idx,
  output logic             sum_vld,
  input  logic             sum_rdy,
  output logic [SUM_W-1:0] sum_data,
  output logic             busy
);

  typedef enum logic [2:0] {IDLE, LOADQ, FEED, WAITRES, SUM} state_t;

  state_t           state;
  state_t           state_nx;
  logic [7:0]       qreg [4];
  logic [1:0]       qcnt;
  logic [1:0]       feat;
  logic             phase;      // 0 = query byte (A), 1 = key byte (B)
  logic [7:0]       kidx;
  logic [SUM_W-1:0] sum;

  logic             q_xfer;
  logic             eng_xfer;
  logic             res_xfer;
  logic             last_key;
  logic [SUM_W:0]   sum_ext;
  logic [SUM_W-1:0] sum_sat;

  assign last_key = (kidx == 8'(NKEYS - 1));
  // one extra bit catches the carry so the sum clamps instead of wrapping
  assign sum_ext  = {1'b0, sum} + {{(SUM_W - 8){1'b0}}, res_data};
  assign sum_sat  = sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];

  // next state, handshake outputs and transfer strobes; everything forced low while in reset
  always_comb begin
    state_nx = state;
    q_rdy    = 1'b0;
    k_rdy    = 1'b0;
    eng_vld  = 1'b0;
    eng_data = 8'd0;
    res_rdy  = 1'b0;
    sc_vld   = 1'b0;
    sc_data  = 9'd0;
    sc_idx   = 8'd0;
    sum_vld  = 1'b0;
    sum_data = '0;
    busy     = 1'b0;
    q_xfer   = 1'b0;
    eng_xfer = 1'b0;
    res_xfer = 1'b0;
    if (!rst) begin
      busy = (state != IDLE);
      case (state)
        IDLE: begin
          q_rdy  = 1'b1;
          q_xfer = q_vld;
          if (q_vld) state_nx = LOADQ;
        end
        LOADQ: begin
          q_rdy  = 1'b1;
          q_xfer = q_vld;
          if (q_vld && qcnt == 2'd3) state_nx = FEED;
        end
        FEED: begin
          if (!phase) begin
            eng_vld  = 1'b1;
            eng_data = qreg[feat];
            eng_xfer = eng_rdy;
          end else begin
            // key byte goes straight through so it is consumed only with the engine beat
            eng_vld  = k_vld;
            eng_data = k_data;
            k_rdy    = eng_rdy;
            eng_xfer = k_vld & eng_rdy;
            if (k_vld && eng_rdy && feat == 2'd3) state_nx = WAITRES;
          end
        end
        WAITRES: begin
          res_rdy  = sc_rdy;
          sc_vld   = res_vld;
          sc_data  = res_data;
          sc_idx   = kidx;
          res_xfer = res_vld & sc_rdy;
          if (res_vld && sc_rdy) state_nx = last_key ? SUM : FEED;
        end
        SUM: begin
          sum_vld  = 1'b1;
          sum_data = sum;
          if (sum_rdy) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // query storage, beat position, key index and running sum
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) qreg[i] <= 8'd0;
      qcnt  <= 2'd0;
      feat  <= 2'd0;
      phase <= 1'b0;
      kidx  <= 8'd0;
      sum   <= '0;
    end else begin
      if (q_xfer) begin
        if (state == IDLE) begin
          qreg[0] <= q_data;
          qcnt    <= 2'd1;
        end else begin
          qreg[qcnt] <= q_data;
          qcnt       <= qcnt + 2'd1;
          if (qcnt == 2'd3) begin
            kidx  <= 8'd0;
            feat  <= 2'd0;
            phase <= 1'b0;
            sum   <= '0;
          end
        end
      end
      if (eng_xfer) begin
        phase <= ~phase;
        if (phase) feat <= feat + 2'd1;
      end
      if (res_xfer) begin
        sum <= sum_sat;
        if (!last_key) begin
          kidx  <= kidx + 8'd1;
          feat  <= 2'd0;
          phase <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_attn_row_sched.sv
// tb/tb_attn_row_sched.sv - randomized scoreboard bench for attn_row_sched
module tb_attn_row_sched;

  localparam int NK = 3;
  localparam int SW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          q_vld = 1'b0, q_rdy;
  logic [7:0]    q_data = 8'd0;
  logic          k_vld = 1'b0, k_rdy;
  logic [7:0]    k_data = 8'd0;
  logic          eng_vld, eng_rdy = 1'b0;
  logic [7:0]    eng_data;
  logic          res_vld = 1'b0, res_rdy;
  logic [8:0]    res_data = 9'd0;
  logic          sc_vld, sc_rdy = 1'b0;
  logic [8:0]    sc_data;
  logic [7:0]    sc_idx;
  logic          sum_vld, sum_rdy = 1'b0;
  logic [SW-1:0] sum_data;
  logic          busy;

  attn_row_sched #(.NKEYS(NK), .SUM_W(SW)) dut (
    .clk(clk), .rst(rst),
    .q_vld(q_vld), .q_rdy(q_rdy), .q_data(q_data),
    .k_vld(k_vld), .k_rdy(k_rdy), .k_data(k_data),
    .eng_vld(eng_vld), .eng_rdy(eng_rdy), .eng_data(eng_data),
    .res_vld(res_vld), .res_rdy(res_rdy), .res_data(res_data),
    .sc_vld(sc_vld), .sc_rdy(sc_rdy), .sc_data(sc_data), .sc_idx(sc_idx),
    .sum_vld(sum_vld), .sum_rdy(sum_rdy), .sum_data(sum_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic go = 1'b0;

  logic [7:0]  q_in[$];
  logic [7:0]  k_in[$];
  logic [7:0]  eng_exp[$];
  logic [8:0]  score_src[$];
  logic [16:0] sc_exp[$];
  logic [SW-1:0] sum_exp[$];

  logic [7:0] rq [4];
  logic [7:0] rk [NK][4];
  logic [8:0] rs [NK];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: engine sees q0,k0,q1,k1,... per key; scores echo in order with key index; sum clamps at all-ones.
  task automatic add_row(input logic [7:0] qv[4], input logic [7:0] kv[NK][4], input logic [8:0] sv[NK]);
    int total;
    int maxv;
    total = 0;
    maxv = (1 << SW) - 1;
    for (int f = 0; f < 4; f++) q_in.push_back(qv[f]);
    for (int k = 0; k < NK; k++) begin
      for (int f = 0; f < 4; f++) begin
        eng_exp.push_back(qv[f]);
        eng_exp.push_back(kv[k][f]);
        k_in.push_back(kv[k][f]);
      end
      score_src.push_back(sv[k]);
      sc_exp.push_back({k[7:0], sv[k]});
      total += int'(sv[k]);
    end
    sum_exp.push_back((total > maxv) ? SW'(maxv) : SW'(total));
  endtask

  // query byte driver
  logic q_acc = 1'b0;
  initial begin
    wait (go);
    forever begin
      @(negedge clk);
      if (q_vld && q_acc) q_vld = 1'b0;
      if (!q_vld && q_in.size() > 0 && $urandom_range(3) != 0) begin
        q_vld  = 1'b1;
        q_data = q_in.pop_front();
      end
      #2;
      q_acc = q_vld && q_rdy;
    end
  end

  // key byte driver
  logic k_acc = 1'b0;
  initial begin
    wait (go);
    forever begin
      @(negedge clk);
      if (k_vld && k_acc) k_vld = 1'b0;
      if (!k_vld && k_in.size() > 0 && $urandom_range(3) != 0) begin
        k_vld  = 1'b1;
        k_data = k_in.pop_front();
      end
      #2;
      k_acc = k_vld && k_rdy;
    end
  end

  // engine model: checks byte order and hold, returns one score per 8 beats
  int   beats = 0;
  int   lat = 0;
  logic res_pend = 1'b0;
  logic res_acc = 1'b0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = 8'd0;
  initial begin
    wait (go);
    forever begin
      @(negedge clk);
      if (res_vld && res_acc) res_vld = 1'b0;
      eng_rdy = ($urandom_range(3) != 0);
      if (!res_vld && res_pend) begin
        if (lat == 0) begin
          res_vld  = 1'b1;
          res_data = score_src.pop_front();
          res_pend = 1'b0;
        end else lat--;
      end
      #2;
      res_acc = res_vld && res_rdy;
      if (prev_stall) check("eng_hold", {eng_vld, eng_data}, {1'b1, prev_data});
      prev_stall = eng_vld && !eng_rdy;
      prev_data  = eng_data;
      if (eng_vld && eng_rdy) begin
        if (eng_exp.size() == 0) check("eng_unexpected_beat", 1, 0);
        else check("eng_byte", eng_data, eng_exp.pop_front());
        beats++;
        if (beats == 8) begin
          beats    = 0;
          res_pend = 1'b1;
          lat      = $urandom_range(3);
        end
      end
    end
  end

  // score monitor
  initial begin
    wait (go);
    forever begin
      @(negedge clk);
      sc_rdy = ($urandom_range(3) != 0);
      #2;
      if (res_vld) begin
        check("res_rdy_follows_sc_rdy", res_rdy, sc_rdy);
        check("sc_vld_passthru", sc_vld, 1'b1);
      end
      if (sc_vld && sc_rdy) begin
        if (sc_exp.size() == 0) check("sc_unexpected", 1, 0);
        else check("score", {sc_idx, sc_data}, sc_exp.pop_front());
      end
    end
  end

  // sum monitor
  initial begin
    wait (go);
    forever begin
      @(negedge clk);
      sum_rdy = ($urandom_range(2) != 0);
      #2;
      if (sum_vld && sum_rdy) begin
        if (sum_exp.size() == 0) check("sum_unexpected", 1, 0);
        else check("row_sum", sum_data, sum_exp.pop_front());
      end
    end
  end

  initial begin
    // outputs during reset
    repeat (2) @(negedge clk);
    #2;
    check("reset_outputs", {q_rdy, k_rdy, eng_vld, res_rdy, sc_vld, sum_vld, busy,
                            eng_data, sc_data, sc_idx, sum_data}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("idle_q_rdy", q_rdy, 1'b1);
    check("idle_busy", busy, 1'b0);

    // load a query and advance into FEED up to feat=2, phase A
    q_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      q_data = 8'(8'h11 * (i + 1));
      @(negedge clk);
    end
    q_vld   = 1'b0;
    k_vld   = 1'b1;
    k_data  = 8'h5a;
    eng_rdy = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    check("midfeed_busy", busy, 1'b1);
    check("midfeed_eng", {eng_vld, eng_data}, {1'b1, 8'h33});
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2;
    check("midfeed_reset_outputs", {q_rdy, k_rdy, eng_vld, res_rdy, sc_vld, sum_vld, busy,
                                    eng_data, sc_data, sc_idx, sum_data}, 64'd0);
    rst     = 1'b0;
    k_vld   = 1'b0;
    eng_rdy = 1'b0;
    @(negedge clk);
    #2;
    check("after_reset_idle", {q_rdy, busy, eng_vld, k_rdy}, {1'b1, 1'b0, 1'b0, 1'b0});

    // happy path row
    for (int f = 0; f < 4; f++) rq[f] = 8'h40;
    for (int k = 0; k < NK; k++) for (int f = 0; f < 4; f++) rk[k][f] = 8'h40;
    rs[0] = 9'h040; rs[1] = 9'h050; rs[2] = 9'h010;
    add_row(rq, rk, rs);
    // saturation row
    for (int f = 0; f < 4; f++) rq[f] = 8'(f + 1);
    for (int k = 0; k < NK; k++) for (int f = 0; f < 4; f++) rk[k][f] = 8'(8'h80 + k * 4 + f);
    for (int k = 0; k < NK; k++) rs[k] = 9'h1ff;
    add_row(rq, rk, rs);
    // random rows, some small enough to stay below the clamp
    for (int r = 0; r < 12; r++) begin
      for (int f = 0; f < 4; f++) rq[f] = 8'($urandom);
      for (int k = 0; k < NK; k++) for (int f = 0; f < 4; f++) rk[k][f] = 8'($urandom);
      for (int k = 0; k < NK; k++)
        rs[k] = (r % 2 == 0) ? 9'($urandom_range(0, 300)) : 9'($urandom);
      add_row(rq, rk, rs);
    end

    go = 1'b1;
    for (int i = 0; i < 20000 && sum_exp.size() > 0; i++) @(negedge clk);
    if (sum_exp.size() > 0) check("timeout_rows_pending", sum_exp.size(), 0);
    repeat (5) @(negedge clk);
    check("scores_drained", sc_exp.size(), 0);
    check("engine_beats_drained", eng_exp.size(), 0);
    #2;
    check("final_idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
